// File: rtl/uart_frame_sequencer.sv
// Frame sequencer: UART RX FIFO -> frame RAM -> processor -> UART TX FIFO.
// Owns the RAM port and both FIFO strobes for one pass per frame.
module uart_frame_sequencer #(
    parameter int FRAME_BYTES = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rd_uart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              proc_start,
    input  logic              proc_done,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [7:0]        frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        START,
        PROC,
        FETCH,
        SEND
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_empty)
                        state <= RECV;
                end
                RECV: begin
                    if (!rx_empty) begin
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= START;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                START: state <= PROC;
                PROC: begin
                    if (proc_done) begin
                        cnt   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: state <= SEND;
                SEND: begin
                    // tx_full holds address and data until the push lands
                    if (!tx_full) begin
                        if (cnt == LAST) begin
                            cnt         <= '0;
                            state       <= IDLE;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_uart    = (state == RECV) && !rx_empty;
    assign mem_we     = rd_uart;
    assign wr_uart    = (state == SEND) && !tx_full;
    assign proc_start = (state == START);
    assign busy       = (state != IDLE);
    assign mem_addr   = cnt;
    assign mem_wdata  = rx_data;
    assign tx_data    = mem_rdata;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: FIFO, RAM and processor models
// around a 32-byte instance and a 1-byte instance.
module tb_uart_frame_sequencer;

    localparam int FB = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 32-byte instance
    logic          rx_empty = 1'b1;
    logic [7:0]    rx_data = 8'd0;
    logic          rd_uart, mem_we, proc_start, wr_uart, busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, tx_data, frame_count;
    logic [7:0]    mem_rdata = 8'd0;
    logic          proc_done = 1'b0;
    logic          tx_full = 1'b0;

    uart_frame_sequencer #(.FRAME_BYTES(FB), .ADDR_W(AW)) u0 (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .rx_data(rx_data), .rd_uart(rd_uart),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .proc_start(proc_start),
        .proc_done(proc_done), .tx_full(tx_full), .wr_uart(wr_uart),
        .tx_data(tx_data), .busy(busy), .frame_count(frame_count)
    );

    // 1-byte instance
    logic       rx_empty1 = 1'b1;
    logic [7:0] rx_data1 = 8'd0;
    logic       rd_uart1, mem_we1, proc_start1, wr_uart1, busy1;
    logic [0:0] mem_addr1;
    logic [7:0] mem_wdata1, tx_data1, frame_count1;
    logic [7:0] mem_rdata1 = 8'd0;
    logic       proc_done1 = 1'b0;

    uart_frame_sequencer #(.FRAME_BYTES(1), .ADDR_W(1)) u1 (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty1), .rx_data(rx_data1), .rd_uart(rd_uart1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .proc_start(proc_start1),
        .proc_done(proc_done1), .tx_full(1'b0), .wr_uart(wr_uart1),
        .tx_data(tx_data1), .busy(busy1), .frame_count(frame_count1)
    );

    // environment state for u0
    logic [7:0] ram [0:FB-1];
    logic [7:0] rxq[$];
    logic [7:0] frame_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    logic [7:0] held;
    int cyc = 0;
    int last_pop = 0, first_pop = 0, done_cyc = 0;
    int pcnt = 0, lat = 5, pushed = 0, starts = 0;
    int stall_left = 0;
    bit stall_req = 0, stall_fired = 0, first_wr = 0, toggle = 0;

    always @(posedge clk) begin
        cyc++;
        mem_rdata <= ram[mem_addr];
        if (reset) begin
            frame_q.delete();
            exp_tx.delete();
            pcnt = 0;
            pushed = 0;
            stall_left = 0;
            first_wr = 0;
            proc_done <= 1'b0;
        end else begin
            chk("strobe_excl", (int'(rd_uart) + int'(wr_uart)
                + int'(proc_start)) < 2, 1);
            chk("we_eq_rd", mem_we, rd_uart);
            if (rd_uart) begin
                chk("pop_empty", rx_empty, 0);
                chk("wr_addr", mem_addr, frame_q.size());
                if (rxq.size() > 0) begin
                    chk("wdata", mem_wdata, rxq[0]);
                    if (frame_q.size() == 0) first_pop = cyc;
                    frame_q.push_back(rxq.pop_front());
                end
                last_pop = cyc;
            end
            if (mem_we) ram[mem_addr] = mem_wdata;
            proc_done <= 1'b0;
            if (proc_start) begin
                chk("start_lat", cyc - last_pop, 1);
                chk("frame_len", frame_q.size(), FB);
                starts++;
                for (int i = 0; i < FB; i++) ram[i] = ~ram[i];
                exp_tx.delete();
                foreach (frame_q[i]) exp_tx.push_back(~frame_q[i]);
                frame_q.delete();
                pushed = 0;
                first_wr = 1;
                pcnt = lat;
            end
            if (pcnt > 0) begin
                pcnt--;
                if (pcnt == 0) proc_done <= 1'b1;
            end
            if (proc_done) done_cyc = cyc;
            if (stall_left > 0) begin
                chk("stall_wr", wr_uart, 0);
                chk("stall_addr", mem_addr, 4);
                if (stall_left == 9) held = tx_data;
                else if (stall_left < 9) chk("stall_data", tx_data, held);
                stall_left--;
            end
            if (wr_uart) begin
                chk("push_full", tx_full, 0);
                chk("tx_addr", mem_addr, pushed);
                if (first_wr) chk("first_tx_lat", cyc - done_cyc, 2);
                first_wr = 0;
                tx_log.push_back(tx_data);
                chk("tx_pending", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0)
                    chk("tx_data", tx_data, exp_tx.pop_front());
                pushed++;
                if (stall_req && !stall_fired && pushed == 4) begin
                    stall_left = 10;
                    stall_fired = 1;
                end
            end
        end
        tx_full <= (stall_left > 0);
        rx_empty <= (toggle && cyc[0]) || (rxq.size() == 0);
        rx_data <= (rxq.size() > 0) ? rxq[0] : 8'd0;
    end

    // environment for u1: endless RX source, 1-cycle processor
    logic [7:0] ram1 [0:1];
    logic [7:0] last1 = 8'd0, exp1 = 8'd0;
    int frames1 = 0;
    bit run1 = 0;

    always @(posedge clk) begin
        mem_rdata1 <= ram1[mem_addr1];
        rx_empty1 <= !run1;
        rx_data1 <= 8'($urandom);
        proc_done1 <= 1'b0;
        if (reset) begin
            frames1 = 0;
        end else begin
            if (rd_uart1) last1 = rx_data1;
            if (mem_we1) ram1[mem_addr1] = mem_wdata1;
            if (proc_start1) begin
                ram1[0] = ~ram1[0];
                exp1 = ~last1;
                proc_done1 <= 1'b1;
            end
            if (wr_uart1) begin
                chk("fb1_tx", tx_data1, exp1);
                frames1++;
            end
        end
    end

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) rxq.push_back(8'($urandom));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_count !== 8'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", n < budget, 1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd"}, rd_uart, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_wr"}, wr_uart, 0);
        chk({tag, "_start"}, proc_start, 0);
        chk({tag, "_addr"}, mem_addr, 0);
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        chk("rst_fcnt", frame_count, 0);
        chk("rst_fcnt1", frame_count1, 0);
        reset = 1'b0;
        @(negedge clk);

        // frame 1: 0x00..0x1F, processor inverts, done after 5
        lat = 5;
        tx_log.delete();
        for (int i = 0; i < FB; i++) rxq.push_back(8'(i));
        wait_frames(1, 1000);
        chk("f1_starts", starts, 1);
        chk("f1_span", last_pop - first_pop, FB - 1);
        chk("f1_txcnt", tx_log.size(), FB);
        if (tx_log.size() == FB) begin
            chk("f1_tx_first", tx_log[0], 8'hFF);
            chk("f1_tx_last", tx_log[FB-1], 8'hE0);
        end
        chk("f1_left", exp_tx.size(), 0);
        @(negedge clk);
        chk("f1_busy", busy, 0);
        chk("f1_fcnt", frame_count, 1);

        // frame 2: rx_empty toggling every other cycle
        toggle = 1;
        lat = $urandom_range(1, 8);
        push_rand(FB);
        wait_frames(2, 2000);
        toggle = 0;
        chk("f2_starts", starts, 2);

        // frame 3: tx_full held 10 cycles at the 5th output byte
        stall_req = 1;
        lat = $urandom_range(1, 8);
        push_rand(FB);
        wait_frames(3, 2000);
        chk("f3_stall_hit", stall_fired, 1);
        stall_req = 0;

        // frames 4/5: 40 bytes preloaded, 8 stay behind
        lat = $urandom_range(1, 8);
        push_rand(40);
        wait_frames(4, 2000);
        chk("f4_left_in_fifo", rxq.size(), 8);
        push_rand(FB - 8);
        wait_frames(5, 2000);
        chk("f5_fifo_empty", rxq.size(), 0);
        chk("f5_starts", starts, 5);

        // reset in the middle of RECV at byte 17
        push_rand(FB);
        n = 0;
        while (frame_q.size() < 17 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("mid_timeout", n < 500, 1);
        reset = 1'b1;
        #1;
        chk_idle_outputs("mid");
        chk("mid_fcnt", frame_count, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_fifo_kept", rxq.size(), FB - 17);
        push_rand(17);
        wait_frames(1, 2000);
        chk("mid_fifo_empty", rxq.size(), 0);

        // 1-byte frames: 256 completions wrap frame_count
        chk("fb1_idle_fcnt", frame_count1, 0);
        run1 = 1;
        n = 0;
        while (frames1 < 255 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("fb1_timeout1", n < 5000, 1);
        chk("fb1_255", frame_count1, 255);
        n = 0;
        while (frames1 < 256 && n < 100) begin
            @(negedge clk);
            n++;
        end
        run1 = 0;
        chk("fb1_timeout2", n < 100, 1);
        chk("fb1_wrap", frame_count1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
